// File: rtl/mul32_sig_pkg.sv
// Shared definitions for the multiplier result checker: FSM encoding and MISR constants.
package mul32_sig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SKIP  = 2'b01,
    ST_ACCUM = 2'b10,
    ST_DONE  = 2'b11
  } sig_state_e;

  localparam logic [63:0] MISR_POLY = 64'h0000_0000_0000_001B;
  localparam logic [63:0] MISR_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

  // One MISR fold: shift left, reduce by the polynomial on carry-out, mix in data.
  function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] d);
    return {s[62:0], 1'b0} ^ (s[63] ? MISR_POLY : 64'h0) ^ d;
  endfunction

endpackage

// File: rtl/mul32_sig_chk_misr64.sv
// 64-bit multiple-input signature register; load (seed) takes priority over fold.
module misr64
  import mul32_sig_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  input  logic [63:0] d,
  output logic [63:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= MISR_SEED;
    end else if (en) begin
      q <= misr_step(q, d);
    end
  end

endmodule

// File: rtl/mul32_sig_chk.sv
// Product-stream checker: drops SKIP fill beats, folds N products into a MISR, compares to golden.
module mul32_sig_chk
  import mul32_sig_pkg::*;
#(
  parameter int N    = 4096,
  parameter int SKIP = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [63:0]                golden,
  input  logic                       res_valid,
  input  logic [31:0]                hi,
  input  logic [31:0]                lo,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [63:0]                sig,
  output logic [$clog2(N+1)-1:0]     count
);

  localparam int CNT_W  = $clog2(N + 1);
  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  sig_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [SKIP_W-1:0] skip_q;
  logic [63:0]       golden_q;
  logic              pass_q;
  logic              seeded_q;
  logic              load_c;
  logic              fold_c;
  logic              finish_c;
  logic [63:0]       misr_q;

  misr64 u_misr (
    .clk  (clk),
    .load (load_c),
    .en   (fold_c),
    .d    ({hi, lo}),
    .q    (misr_q)
  );

  // Completion is taken one cycle after the Nth fold so pass sees the post-fold signature.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    fold_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = (SKIP > 0) ? ST_SKIP : ST_ACCUM;
        end
      end
      ST_SKIP: begin
        if (res_valid && skip_q == SKIP_W'(1)) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (count_q == CNT_W'(N)) begin
          finish_c = 1'b1;
          state_d  = ST_DONE;
        end else if (res_valid) begin
          fold_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      skip_q   <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
      seeded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        count_q  <= '0;
        skip_q   <= SKIP_W'(SKIP);
        golden_q <= golden;
        pass_q   <= 1'b0;
        seeded_q <= 1'b1;
      end
      if (state_q == ST_SKIP && res_valid) skip_q <= skip_q - SKIP_W'(1);
      if (fold_c) count_q <= count_q + CNT_W'(1);
      if (finish_c) pass_q <= (misr_q == golden_q);
    end
  end

  // The MISR register itself has no reset; the seeded flag masks it to zero until a run starts.
  assign sig   = seeded_q ? misr_q : 64'h0;
  assign count = count_q;
  assign busy  = (state_q == ST_SKIP) || (state_q == ST_ACCUM);
  assign done  = (state_q == ST_DONE);
  assign pass  = pass_q;

endmodule

// File: tb/tb_mul32_sig_chk.sv
// Directed bench for mul32_sig_chk: one instance with SKIP=0 and one with SKIP=2, both N=4.
module tb_mul32_sig_chk;

  localparam logic [63:0] SEED = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SIG4 = 64'hFFFF_FFFF_FFFF_FF69;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        res_valid = 1'b0;
  logic [63:0] golden = 64'h0;
  logic [31:0] hi = 32'h0;
  logic [31:0] lo = 32'h0;
  logic        sel = 1'b0;

  logic        start_a, start_b, vld_a, vld_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [63:0] sig_a, sig_b;
  logic [2:0]  count_a, count_b;

  int checks = 0;
  int failures = 0;

  assign start_a = start && !sel;
  assign start_b = start && sel;
  assign vld_a   = res_valid && !sel;
  assign vld_b   = res_valid && sel;

  always #5 clk = ~clk;

  mul32_sig_chk #(.N(4), .SKIP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .golden(golden), .res_valid(vld_a),
    .hi(hi), .lo(lo), .busy(busy_a), .done(done_a), .pass(pass_a), .sig(sig_a), .count(count_a)
  );

  mul32_sig_chk #(.N(4), .SKIP(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .golden(golden), .res_valid(vld_b),
    .hi(hi), .lo(lo), .busy(busy_b), .done(done_b), .pass(pass_b), .sig(sig_b), .count(count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs of the instance currently selected.
  function automatic logic [63:0] o_sig();  return sel ? sig_b : sig_a; endfunction
  function automatic logic [63:0] o_cnt();  return sel ? 64'(count_b) : 64'(count_a); endfunction
  function automatic logic        o_busy(); return sel ? busy_b : busy_a; endfunction
  function automatic logic        o_done(); return sel ? done_b : done_a; endfunction
  function automatic logic        o_pass(); return sel ? pass_b : pass_a; endfunction

  task automatic do_start(input logic [63:0] g);
    golden = g; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] h, input logic [31:0] l);
    hi = h; lo = l; res_valid = 1'b1;
    step();
    res_valid = 1'b0; hi = 32'h0; lo = 32'h0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_pass_a", 64'(pass_a), 64'd0);
    chk("rst_sig_a", sig_a, 64'h0);
    chk("rst_count_a", 64'(count_a), 64'd0);
    chk("rst_sig_b", sig_b, 64'h0);

    // Test 1: four zero beats, matching golden
    sel = 1'b0;
    do_start(SIG4);
    chk("t1_busy_start", 64'(o_busy()), 64'd1);
    chk("t1_sig_seed", o_sig(), SEED);
    chk("t1_count0", o_cnt(), 64'd0);
    for (int i = 0; i < 4; i++) beat(32'h0, 32'h0);
    chk("t1_sig", o_sig(), SIG4);
    chk("t1_count", o_cnt(), 64'd4);
    chk("t1_done_early", 64'(o_done()), 64'd0);
    step();
    chk("t1_done", 64'(o_done()), 64'd1);
    chk("t1_pass", 64'(o_pass()), 64'd1);
    chk("t1_busy_end", 64'(o_busy()), 64'd0);
    beat(32'h1234_5678, 32'h9ABC_DEF0);
    chk("t1_sig_frozen", o_sig(), SIG4);
    chk("t1_count_frozen", o_cnt(), 64'd4);

    // Test 2: same stimulus, wrong golden
    do_start(64'h0);
    chk("t2_done_cleared", 64'(o_done()), 64'd0);
    chk("t2_pass_cleared", 64'(o_pass()), 64'd0);
    for (int i = 0; i < 4; i++) beat(32'h0, 32'h0);
    step();
    chk("t2_done", 64'(o_done()), 64'd1);
    chk("t2_pass", 64'(o_pass()), 64'd0);
    chk("t2_sig", o_sig(), SIG4);

    // Test 3: SKIP=2 instance, fill beats carry nonzero data
    sel = 1'b1;
    do_start(SIG4);
    chk("t3_busy", 64'(o_busy()), 64'd1);
    beat(32'hDEAD_BEEF, 32'h0000_0001);
    beat(32'hDEAD_BEEF, 32'h0000_0001);
    chk("t3_sig_after_skip", o_sig(), SEED);
    chk("t3_count_after_skip", o_cnt(), 64'd0);
    for (int i = 0; i < 4; i++) beat(32'h0, 32'h0);
    chk("t3_sig", o_sig(), SIG4);
    step();
    chk("t3_done", 64'(o_done()), 64'd1);
    chk("t3_pass", 64'(o_pass()), 64'd1);

    // Test 4: gaps between valid beats
    sel = 1'b0;
    do_start(SIG4);
    for (int i = 0; i < 4; i++) begin
      int gap;
      beat(32'h0, 32'h0);
      chk("t4_count_beat", o_cnt(), 64'(i + 1));
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) step();
      chk("t4_count_gap", o_cnt(), 64'(i + 1));
    end
    step();
    chk("t4_sig", o_sig(), SIG4);
    chk("t4_done", 64'(o_done()), 64'd1);
    chk("t4_pass", 64'(o_pass()), 64'd1);

    // Test 5: reset mid-run, then a clean run
    do_start(SIG4);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", 64'(o_busy()), 64'd0);
    chk("t5_done", 64'(o_done()), 64'd0);
    chk("t5_sig", o_sig(), 64'h0);
    chk("t5_count", o_cnt(), 64'd0);
    do_start(SIG4);
    for (int i = 0; i < 4; i++) beat(32'h0, 32'h0);
    step();
    chk("t5_sig_rerun", o_sig(), SIG4);
    chk("t5_pass_rerun", 64'(o_pass()), 64'd1);

    // Test 6: start mid-ACCUM with a different golden is ignored
    do_start(SIG4);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    golden = 64'h0; start = 1'b1;
    beat(32'h0, 32'h0);
    start = 1'b0;
    chk("t6_count_mid", o_cnt(), 64'd3);
    chk("t6_busy_mid", 64'(o_busy()), 64'd1);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    chk("t6_count_sat", o_cnt(), 64'd4);
    chk("t6_done", 64'(o_done()), 64'd1);
    chk("t6_pass", 64'(o_pass()), 64'd1);
    chk("t6_sig", o_sig(), SIG4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
